mod_reduce_seq: RTL and testbench
=================================

// Module: mod_reduce_seq
// PURPOSE
//   Sequential modular reducer for the mod-997 calculator family: accepts an IN_WIDTH-bit
//   unsigned operand and returns operand mod MODULUS. Replaces the per-chunk residue LUT
//   banks with one parametrised, iterative datapath.
//   Processing is MSB-first Horner reduction, BITS_PER_CYCLE bits per clock, behind a
//   valid/ready handshake on both sides. It sits between operand capture and the residue
//   adders.
// PARAMETERS
//   MODULUS         997  modulus M; 2 <= M < 2**RES_WIDTH
//   IN_WIDTH        48   operand width; must be a multiple of BITS_PER_CYCLE
//   BITS_PER_CYCLE  6    operand bits consumed per RUN cycle (1..IN_WIDTH)
//   RES_WIDTH       10   residue width
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   i_valid    in   1          operand valid
//   i_ready    out  1          block can accept an operand this cycle
//   i_x        in   IN_WIDTH   operand, unsigned
//   o_valid    out  1          residue valid
//   o_ready    in   1          downstream accepts residue
//   o_residue  out  RES_WIDTH  i_x mod MODULUS, always < MODULUS
//   o_busy     out  1          high in RUN
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, acc=0, count=0.
//     Outputs: o_valid=0, o_residue=0, o_busy=0, i_ready=1.
//   Let N = IN_WIDTH/BITS_PER_CYCLE.
//   FSM IDLE -> RUN -> DONE.
//   - IDLE: i_ready=1. On i_valid&i_ready: latch i_x into shift reg, acc<=0, count<=0,
//     go to RUN.
//   - RUN (N cycles): each cycle take the top BITS_PER_CYCLE bits of the shift reg,
//     MSB first, and shift them out.
//     - Per bit b, combinational chain of BITS_PER_CYCLE stages:
//       t = 2*acc + b; acc = (t >= M) ? t - M : t.
//     - Stage width is RES_WIDTH+1 bits. acc < M is an invariant at every stage.
//     - count increments each cycle. After cycle N (count==N-1): o_residue<=acc_next,
//       go to DONE.
//     - i_ready=0 in RUN; i_valid is ignored.
//   - DONE: o_valid=1 and o_residue is held stable until o_valid&o_ready.
//     - On handshake with no new operand: go to IDLE, o_valid drops the next cycle.
//     - i_ready = o_ready in DONE. If i_valid is also high, the new operand is latched in
//       the same cycle and the FSM goes straight to RUN (back-to-back, no bubble).
//   - Latency: acceptance edge to o_valid high = N+1 clocks (9 with defaults).
//     Throughput: one result per N+1 clocks.
//   - o_residue keeps its last value after the handshake. It is only meaningful while
//     o_valid=1.
//   - Boundaries:
//     - i_x=0 gives 0.
//     - i_x=M gives 0.
//     - i_x=all-ones is correct with no overflow.
//     - BITS_PER_CYCLE=IN_WIDTH gives N=1, so 2-cycle latency.
//   - rst mid-RUN or in DONE aborts the operation and no o_valid pulse is emitted.
//   - Parameter violations (IN_WIDTH%BITS_PER_CYCLE!=0, M>=2**RES_WIDTH, M<2) are caught by
//     an elaboration-time $error in a generate block.
// TESTING
//   1 Reset: assert rst mid-RUN (cycle 3) -> o_valid=0, i_ready=1, o_residue=0 next cycle;
//     no stray o_valid.
//   2 Basic: i_x=400 -> o_residue=400 exactly 9 clocks after acceptance.
//     i_x=997 -> 0. i_x=1000000 -> 9.
//   3 Max operand: i_x=48'hFFFF_FFFF_FFFF -> o_residue=269.
//     i_x=0 -> 0 (N+1 latency kept).
//   4 Backpressure: hold o_ready=0 for 5 cycles in DONE -> o_residue stable, i_ready=0;
//     release -> one-cycle handshake.
//   5 Back-to-back: i_valid held high with i_x=997 then 400, o_ready=1 -> results 0 then
//     400, spaced exactly 9 cycles apart.
//   6 Parameter sweep: BITS_PER_CYCLE in {1,6,48}, MODULUS in {3,997}; 1000 random
//     operands each -> match reference % model, latency N+1.

Source files
------------

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: sequential MSB-first Horner reducer, returns i_x mod MODULUS.
//   clk, rst (async, active high)
//   i_valid/i_ready/i_x          operand handshake
//   o_valid/o_ready/o_residue    residue handshake; o_residue < MODULUS
//   o_busy                       high while reducing
module mod_reduce_seq #(
  parameter int unsigned MODULUS        = 997,
  parameter int unsigned IN_WIDTH       = 48,
  parameter int unsigned BITS_PER_CYCLE = 6,
  parameter int unsigned RES_WIDTH      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [IN_WIDTH-1:0]  i_x,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [RES_WIDTH-1:0] o_residue,
  output logic                 o_busy
);

  localparam int unsigned BPC_SAFE = (BITS_PER_CYCLE == 0) ? 1 : BITS_PER_CYCLE;
  localparam int unsigned N        = IN_WIDTH / BPC_SAFE;
  localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]      LAST = CW'(N - 1);
  localparam logic [RES_WIDTH:0] M_W  = MODULUS[RES_WIDTH:0];

  generate
    if ((BITS_PER_CYCLE == 0) || (BITS_PER_CYCLE > IN_WIDTH) ||
        ((IN_WIDTH % BPC_SAFE) != 0) || (MODULUS < 2) ||
        ((MODULUS >> RES_WIDTH) != 0)) begin : g_bad_param
      $error("mod_reduce_seq: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [IN_WIDTH-1:0]    shreg_q, shreg_d;
  logic [RES_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RES_WIDTH-1:0]   res_q, res_d;

  logic [RES_WIDTH:0]     t;
  logic [RES_WIDTH-1:0]   acc_next;

  // One conditional subtract per bit keeps acc < M, since 2*acc+b <= 2M-1.
  always_comb begin
    t        = '0;
    acc_next = acc_q;
    for (int unsigned i = 0; i < BPC_SAFE; i++) begin
      t = {acc_next, shreg_q[IN_WIDTH-1-i]};
      if (t >= M_W) t = t - M_W;
      acc_next = t[RES_WIDTH-1:0];
    end
  end

  assign i_ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && o_ready);
  assign o_valid   = (state_q == S_DONE);
  assign o_busy    = (state_q == S_RUN);
  assign o_residue = res_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          shreg_d = i_x;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        shreg_d = shreg_q << BPC_SAFE;
        acc_d   = acc_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = acc_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Output handshake and a new operand may coincide: reload with no bubble.
        if (o_ready) begin
          if (i_valid) begin
            shreg_d = i_x;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
module tb_mod_reduce_seq;

  localparam int unsigned NCFG = 6;
  localparam int unsigned NOPS = 1000;
  localparam int unsigned BPC_T [NCFG] = '{6, 1, 48, 6, 1, 48};
  localparam int unsigned MOD_T [NCFG] = '{997, 997, 997, 3, 3, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Directed DUT, default parameters
  logic        rst;
  logic        i_valid, i_ready, o_valid, o_ready, o_busy;
  logic [47:0] i_x;
  logic [9:0]  o_residue;

  mod_reduce_seq #(.MODULUS(997), .IN_WIDTH(48), .BITS_PER_CYCLE(6), .RES_WIDTH(10)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_x(i_x),
    .o_valid(o_valid), .o_ready(o_ready), .o_residue(o_residue), .o_busy(o_busy)
  );

  // Randomised parameter sweep, each instance against x % M
  logic            rst_r;
  logic [NCFG-1:0] done = '0;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned BPC = BPC_T[g];
    localparam int unsigned M   = MOD_T[g];
    localparam int unsigned N   = 48 / BPC;

    logic        iv, ir, ov, ordy, ob;
    logic [47:0] ix;
    logic [9:0]  res;

    mod_reduce_seq #(.MODULUS(M), .IN_WIDTH(48), .BITS_PER_CYCLE(BPC), .RES_WIDTH(10)) u_rnd (
      .clk(clk), .rst(rst_r), .i_valid(iv), .i_ready(ir), .i_x(ix),
      .o_valid(ov), .o_ready(ordy), .o_residue(res), .o_busy(ob)
    );

    initial begin
      longint unsigned q[$];
      longint unsigned exp_r;
      logic [63:0]     r64;
      int unsigned     got, cyc, acc_cyc, sel;
      bit              prev_v, accepted;
      got = 0; cyc = 0; acc_cyc = 0; prev_v = 0; accepted = 0;
      iv = 1'b0; ix = '0; ordy = 1'b0;
      @(negedge clk);
      while (rst_r) @(negedge clk);
      while (got < NOPS && cyc < 90000) begin
        @(negedge clk);
        cyc++;
        if (!iv || accepted) begin
          accepted = 0;
          if ($urandom_range(3) != 0) begin
            sel = $urandom_range(9);
            r64 = {$urandom(), $urandom()};
            case (sel)
              0:       ix = '1;
              1:       ix = '0;
              2:       ix = 48'(M);
              3:       ix = 48'(M - 1);
              default: ix = r64[47:0];
            endcase
            iv = 1'b1;
          end else begin
            iv = 1'b0;
          end
        end
        ordy = ($urandom_range(3) != 0);
        #1;
        if (ov && !prev_v) check($sformatf("latency cfg%0d", g), cyc - acc_cyc, N + 1);
        prev_v = ov;
        if (ov && ordy) begin
          exp_r = (q.size() != 0) ? q.pop_front() : 64'hFFFF;
          check($sformatf("residue cfg%0d", g), res, exp_r);
          got++;
        end
        if (iv && ir) begin
          q.push_back(longint'(ix) % longint'(M));
          acc_cyc  = cyc;
          accepted = 1;
        end
      end
      check($sformatf("completed ops cfg%0d", g), got, NOPS);
      done[g] = 1'b1;
    end
  end

  typedef struct {
    logic [47:0] x;
    logic [9:0]  exp;
  } vec_t;

  task automatic run_one(input logic [47:0] x, output logic [9:0] r, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_x = x; o_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = o_residue;
  endtask

  initial begin
    vec_t        tbl[8];
    logic [9:0]  r;
    int          lat, acc_cnt, stray, t;
    int          v_cyc[$];
    logic [9:0]  v_res[$];

    tbl[0] = '{48'd400, 10'd400};
    tbl[1] = '{48'd997, 10'd0};
    tbl[2] = '{48'd1000000, 10'd9};
    tbl[3] = '{48'hFFFF_FFFF_FFFF, 10'd269};
    tbl[4] = '{48'd0, 10'd0};
    tbl[5] = '{48'd1994, 10'd0};
    tbl[6] = '{48'd998, 10'd1};
    tbl[7] = '{48'd996, 10'd996};

    rst = 1'b1; rst_r = 1'b1;
    i_valid = 1'b0; i_x = '0; o_ready = 1'b0;
    @(negedge clk);
    check("reset o_valid", o_valid, 0);
    check("reset i_ready", i_ready, 1);
    check("reset o_residue", o_residue, 0);
    check("reset o_busy", o_busy, 0);
    @(negedge clk);
    rst = 1'b0; rst_r = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_one(tbl[i].x, r, lat);
      check($sformatf("residue vec%0d", i), r, tbl[i].exp);
      check($sformatf("latency vec%0d", i), lat, 9);
    end

    // Backpressure: result held while o_ready low
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b1; i_x = 48'd1000000; o_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    t = 0;
    while (!o_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp o_valid", o_valid, 1);
      check("bp o_residue", o_residue, 9);
      check("bp i_ready", i_ready, 0);
      @(negedge clk);
    end
    o_ready = 1'b1;
    #1;
    check("bp release i_ready", i_ready, 1);
    @(negedge clk);
    check("bp after handshake o_valid", o_valid, 0);
    check("bp after handshake o_residue", o_residue, 9);

    // Back-to-back with i_valid held high
    @(negedge clk);
    i_valid = 1'b1; i_x = 48'd997; o_ready = 1'b1;
    acc_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (i_valid && i_ready) acc_cnt++;
      if (o_valid) begin
        v_cyc.push_back(c);
        v_res.push_back(o_residue);
      end
      @(negedge clk);
      if (acc_cnt == 1) i_x = 48'd400;
      if (acc_cnt >= 2) i_valid = 1'b0;
    end
    check("b2b result count", v_cyc.size(), 2);
    if (v_cyc.size() == 2) begin
      check("b2b first residue", v_res[0], 0);
      check("b2b second residue", v_res[1], 400);
      check("b2b first time", v_cyc[0], 9);
      check("b2b spacing", v_cyc[1] - v_cyc[0], 9);
    end

    // Reset mid-RUN
    @(negedge clk);
    i_valid = 1'b1; i_x = 48'd1000000; o_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun o_busy", o_busy, 1);
    rst = 1'b1;
    #1;
    check("midrun rst o_valid", o_valid, 0);
    check("midrun rst i_ready", i_ready, 1);
    check("midrun rst o_busy", o_busy, 0);
    @(negedge clk);
    check("midrun rst o_residue", o_residue, 0);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid) stray++;
    end
    check("no stray o_valid", stray, 0);

    t = 0;
    while (!(&done) && t < 100000) begin
      @(negedge clk);
      t++;
    end
    check("sweep finished", done, {NCFG{1'b1}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
